vc_frame_scheduler: RTL and testbench

//  Per-TX-port frame scheduler for the crossbar virtual-channel queues. It arbitrates round-robin

---
 rtl/vc_frame_scheduler_pkg.sv | 14 +
 rtl/vc_frame_scheduler_if.sv | 27 ++
 rtl/vc_frame_scheduler_rr_pick.sv | 41 ++++
 rtl/vc_frame_scheduler.sv | 127 ++++++++++++
 tb/tb_vc_frame_scheduler.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_frame_scheduler_pkg.sv
// Shared types and defaults for the per-TX-port virtual-channel frame scheduler.
package vc_frame_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    IFG
  } sched_state_e;

  localparam int C_DEFAULT_NUM_VC      = 3;
  localparam int C_DEFAULT_IFG_CYCLES  = 12;
  localparam int C_DEFAULT_STALL_LIMIT = 64;

endpackage

// File: rtl/vc_frame_scheduler_if.sv
// Queue-side bundle between one TX port scheduler and its VC queues / data mux.
interface vc_frame_scheduler_if #(
  parameter int P_NUM_VC = 3
);

  localparam int SEL_W = $clog2(P_NUM_VC);

  logic                enable_i;
  logic [P_NUM_VC-1:0] vc_empty_i;
  logic [P_NUM_VC-1:0] vc_eof_i;
  logic [P_NUM_VC-1:0] vc_read_o;
  logic [SEL_W-1:0]    sel_o;
  logic                tx_ctrl_o;
  logic                busy_o;
  logic                abort_o;

  modport master (
    output enable_i, vc_empty_i, vc_eof_i,
    input  vc_read_o, sel_o, tx_ctrl_o, busy_o, abort_o
  );

  modport slave (
    input  enable_i, vc_empty_i, vc_eof_i,
    output vc_read_o, sel_o, tx_ctrl_o, busy_o, abort_o
  );

endinterface

// File: rtl/vc_frame_scheduler_rr_pick.sv
// Rotate-priority picker: first requester strictly after last_i, wrapping to index 0.
module vc_frame_scheduler_rr_pick #(
  parameter  int P_WIDTH = 3,
  localparam int IDX_W   = $clog2(P_WIDTH)
) (
  input  logic [P_WIDTH-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [P_WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic             hit_hi;
  logic             hit_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    // Descending scan: the lowest index in each half is the one left standing.
    for (int i = P_WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        if (IDX_W'(i) > last_i) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IDX_W'(i);
        end
      end
    end
    valid_o  = hit_hi | hit_lo;
    idx_o    = hit_hi ? idx_hi : idx_lo;
    onehot_o = valid_o ? (P_WIDTH'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/vc_frame_scheduler.sv
// Per-TX-port frame scheduler: round-robin grant held for a whole frame, forced
// inter-frame gap, and abort of frames whose queue starves mid-frame.
module vc_frame_scheduler
  import vc_frame_scheduler_pkg::*;
#(
  parameter int P_NUM_VC      = C_DEFAULT_NUM_VC,
  parameter int P_IFG_CYCLES  = C_DEFAULT_IFG_CYCLES,
  parameter int P_STALL_LIMIT = C_DEFAULT_STALL_LIMIT
) (
  input logic                 clk_i,
  input logic                 rst_i,
  vc_frame_scheduler_if.slave bus
);

  localparam int SEL_W   = $clog2(P_NUM_VC);
  localparam int IFG_W   = $clog2(P_IFG_CYCLES + 1);
  localparam int STALL_W = $clog2(P_STALL_LIMIT + 1);

  sched_state_e        state_q, state_d;
  logic [P_NUM_VC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [IFG_W-1:0]    ifg_cnt_q, ifg_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [P_NUM_VC-1:0] req;
  logic [P_NUM_VC-1:0] pick_onehot;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                arb_now;
  logic [P_NUM_VC-1:0] vc_read;
  logic                abort;

  assign req = ~bus.vc_empty_i & {P_NUM_VC{bus.enable_i}};

  // One picker serves both the IDLE decision and the last IFG cycle.
  vc_frame_scheduler_rr_pick #(
    .P_WIDTH (P_NUM_VC)
  ) u_rr_pick (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      last_q      <= SEL_W'(P_NUM_VC - 1);
      ifg_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      ifg_cnt_q   <= ifg_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    ifg_cnt_d   = ifg_cnt_q;
    stall_cnt_d = stall_cnt_q;
    vc_read     = '0;
    abort       = 1'b0;
    arb_now     = 1'b0;

    unique case (state_q)
      IDLE: arb_now = 1'b1;
      XFER: begin
        // Read strobe comes straight from the FWFT empty flag: no added latency.
        vc_read = gnt_q & ~bus.vc_empty_i;
        if (|vc_read) begin
          stall_cnt_d = '0;
          if (bus.vc_eof_i[sel_q]) begin
            state_d   = IFG;
            gnt_d     = '0;
            ifg_cnt_d = IFG_W'(P_IFG_CYCLES - 1);
          end
        end else if (stall_cnt_q == STALL_W'(P_STALL_LIMIT - 1)) begin
          abort       = 1'b1;
          stall_cnt_d = '0;
          state_d     = IFG;
          gnt_d       = '0;
          ifg_cnt_d   = IFG_W'(P_IFG_CYCLES - 1);
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      IFG: begin
        if (ifg_cnt_q == '0) arb_now = 1'b1;
        else                 ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (arb_now) begin
      state_d = pick_valid ? XFER : IDLE;
      if (pick_valid) begin
        gnt_d  = pick_onehot;
        sel_d  = pick_idx;
        last_d = pick_idx;
      end
    end
  end

  assign bus.vc_read_o = vc_read;
  assign bus.tx_ctrl_o = |vc_read;
  assign bus.sel_o     = sel_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.abort_o   = abort;

  a_read_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.vc_read_o));
  a_no_read_empty : assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.vc_read_o & bus.vc_empty_i) == '0);

endmodule

// File: tb/tb_vc_frame_scheduler.sv
// Bench for vc_frame_scheduler: FWFT queue models drive the DUT, and a frame-level
// reference model predicts every output each cycle alongside directed scenario checks.
module tb_vc_frame_scheduler;

  localparam int NV    = 3;
  localparam int IFG   = 12;
  localparam int STALL = 64;
  localparam int SW    = $clog2(NV);

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  vc_frame_scheduler_if #(.P_NUM_VC(NV)) bus ();

  vc_frame_scheduler #(
    .P_NUM_VC      (NV),
    .P_IFG_CYCLES  (IFG),
    .P_STALL_LIMIT (STALL)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle        = 0;

  // Queue contents: one entry per byte, value is its EOF tag.
  bit   vcq[NV][$];
  int   hold_cnt[NV];
  logic enable = 1'b1;

  // Reference model: who owns the port, how many quiet cycles remain, rr history.
  int   m_owner, m_gap, m_last, m_sel, m_stall;
  bit   m_valid = 1'b0;

  logic [NV-1:0] obs_read;
  logic          obs_tx, obs_busy, obs_abort;
  logic [SW-1:0] obs_sel;
  logic [NV-1:0] tr_read[$];
  logic          tr_busy[$];
  logic          tr_abort[$];
  logic [SW-1:0] tr_sel[$];

  function automatic bit q_empty(int v);
    return (hold_cnt[v] > 0) || (vcq[v].size() == 0);
  endfunction

  function automatic void drive_inputs();
    for (int i = 0; i < NV; i++) begin
      bus.vc_empty_i[i] = q_empty(i);
      bus.vc_eof_i[i]   = (vcq[i].size() > 0) ? vcq[i][0] : 1'b0;
    end
    bus.enable_i = enable;
  endfunction

  function automatic void push_frame(int v, int len);
    for (int b = 1; b <= len; b++) vcq[v].push_back(b == len);
  endfunction

  function automatic void clear_trace();
    tr_read.delete();
    tr_busy.delete();
    tr_abort.delete();
    tr_sel.delete();
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_gap   = 0;
    m_last  = NV - 1;
    m_sel   = 0;
    m_stall = 0;
    m_valid = 1'b1;
  endfunction

  function automatic void m_arbitrate();
    if (!enable) return;
    for (int k = 1; k <= NV; k++) begin
      int v = (m_last + k) % NV;
      if (!q_empty(v)) begin
        m_owner = v;
        m_last  = v;
        m_sel   = v;
        m_stall = 0;
        return;
      end
    end
  endfunction

  function automatic void m_advance();
    if (m_owner >= 0) begin
      if (!q_empty(m_owner)) begin
        m_stall = 0;
        if (vcq[m_owner][0]) begin
          m_owner = -1;
          m_gap   = IFG;
        end
      end else if (m_stall == STALL - 1) begin
        m_owner = -1;
        m_gap   = IFG;
        m_stall = 0;
      end else begin
        m_stall++;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      m_arbitrate();
    end
  endfunction

  // One clock: sample on the falling edge, compare to the model, then let the queues pop.
  task automatic step();
    logic [NV-1:0] exp_read;
    logic          exp_busy, exp_abort;
    @(negedge clk_i);
    obs_read  = bus.vc_read_o;
    obs_tx    = bus.tx_ctrl_o;
    obs_busy  = bus.busy_o;
    obs_abort = bus.abort_o;
    obs_sel   = bus.sel_o;
    if (m_valid) begin
      exp_read  = '0;
      exp_abort = 1'b0;
      if (m_owner >= 0) begin
        if (!q_empty(m_owner)) exp_read[m_owner] = 1'b1;
        else exp_abort = (m_stall == STALL - 1);
      end
      exp_busy = (m_owner >= 0) || (m_gap > 0);
      tests_run++;
      if (obs_read !== exp_read) begin
        tests_failed++;
        $display("FAIL model_vc_read cyc=%0d got=%b exp=%b", cycle, obs_read, exp_read);
      end
      tests_run++;
      if (obs_tx !== (|exp_read)) begin
        tests_failed++;
        $display("FAIL model_tx_ctrl cyc=%0d got=%b exp=%b", cycle, obs_tx, |exp_read);
      end
      tests_run++;
      if (obs_busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL model_busy cyc=%0d got=%b exp=%b", cycle, obs_busy, exp_busy);
      end
      tests_run++;
      if (obs_abort !== exp_abort) begin
        tests_failed++;
        $display("FAIL model_abort cyc=%0d got=%b exp=%b", cycle, obs_abort, exp_abort);
      end
      tests_run++;
      if (obs_sel !== SW'(m_sel)) begin
        tests_failed++;
        $display("FAIL model_sel cyc=%0d got=%0d exp=%0d", cycle, obs_sel, m_sel);
      end
    end
    tr_read.push_back(obs_read);
    tr_busy.push_back(obs_busy);
    tr_abort.push_back(obs_abort);
    tr_sel.push_back(obs_sel);
    @(posedge clk_i);
    if (rst_i) m_reset();
    else if (m_valid) m_advance();
    #1;
    for (int i = 0; i < NV; i++)
      if (obs_read[i] && vcq[i].size() > 0) void'(vcq[i].pop_front());
    drive_inputs();
    cycle++;
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < NV; i++) begin
      vcq[i].delete();
      hold_cnt[i] = 0;
    end
    drive_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (obs_read !== '0 || obs_tx !== 1'b0 || obs_busy !== 1'b0 ||
        obs_abort !== 1'b0 || obs_sel !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: read=%b tx=%b busy=%b abort=%b sel=%0d, expected all zero",
               obs_read, obs_tx, obs_busy, obs_abort, obs_sel);
    end
  endtask

  task automatic test_single_frame();
    int first = -1, last = -1, n_ok = 0, n_bad = 0, quiet = 0;
    do_reset();
    push_frame(1, 5);
    drive_inputs();
    clear_trace();
    repeat (30) step();
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] != '0) begin
        if (tr_read[i] == 3'b010 && tr_sel[i] == SW'(1)) n_ok++;
        else n_bad++;
        if (first < 0) first = i;
        last = i;
      end
    end
    for (int i = last + 1; i >= 1 && i < tr_busy.size() && tr_busy[i]; i++) quiet++;
    tests_run++;
    if (n_ok != 5 || n_bad != 0 || first != 1 || last != 5) begin
      tests_failed++;
      $display("FAIL single_frame: good=%0d bad=%0d span=%0d..%0d, required 5/0 at 1..5",
               n_ok, n_bad, first, last);
    end
    tests_run++;
    if (quiet != IFG) begin
      tests_failed++;
      $display("FAIL single_frame_ifg: busy-after-eof=%0d required=%0d", quiet, IFG);
    end
    tests_run++;
    if (tr_busy[tr_busy.size()-1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_frame_idle: busy=%b required 0", tr_busy[tr_busy.size()-1]);
    end
  endtask

  task automatic test_back_to_back();
    int owners[$], lens[$], gaps[$];
    int exp_owner[4] = '{0, 1, 2, 0};
    int seg_owner = -1, len = 0, idle = 0;
    bit in_seg = 0, mixed = 0;
    do_reset();
    push_frame(0, 3);
    push_frame(0, 3);
    push_frame(1, 3);
    push_frame(2, 3);
    drive_inputs();
    clear_trace();
    repeat (90) step();
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] != '0) begin
        int v = 0;
        if ($countones(tr_read[i]) != 1) mixed = 1;
        for (int b = NV - 1; b >= 0; b--) if (tr_read[i][b]) v = b;
        if (in_seg) begin
          if (v != seg_owner) mixed = 1;
          len++;
        end else begin
          if (owners.size() > 0) gaps.push_back(idle);
          owners.push_back(v);
          seg_owner = v;
          in_seg    = 1;
          len       = 1;
        end
        idle = 0;
      end else begin
        if (in_seg) lens.push_back(len);
        in_seg = 0;
        idle++;
      end
    end
    tests_run++;
    if (owners.size() != 4 || mixed) begin
      tests_failed++;
      $display("FAIL b2b_frames: frames=%0d interleaved=%0d required 4/0", owners.size(), mixed);
    end else begin
      for (int f = 0; f < 4; f++) begin
        tests_run++;
        if (owners[f] != exp_owner[f]) begin
          tests_failed++;
          $display("FAIL b2b_order[%0d]: vc=%0d required=%0d", f, owners[f], exp_owner[f]);
        end
        tests_run++;
        if (f >= lens.size() || lens[f] != 3) begin
          tests_failed++;
          $display("FAIL b2b_len[%0d]: got=%0d required=3", f, (f < lens.size()) ? lens[f] : -1);
        end
      end
      for (int g = 0; g < gaps.size(); g++) begin
        tests_run++;
        if (gaps[g] != IFG) begin
          tests_failed++;
          $display("FAIL b2b_gap[%0d]: quiet=%0d required=%0d", g, gaps[g], IFG);
        end
      end
    end
  endtask

  task automatic test_stall_resume();
    int n = 0, n_read = 0, n_abort = 0, n_idle = 0;
    do_reset();
    push_frame(0, 5);
    drive_inputs();
    for (int c = 0; c < 20 && n < 2; c++) begin
      step();
      if (obs_read != '0) n++;
    end
    hold_cnt[0] = 1000;
    drive_inputs();
    clear_trace();
    repeat (10) step();
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] != '0) n_read++;
      if (tr_abort[i]) n_abort++;
      if (!tr_busy[i]) n_idle++;
    end
    tests_run++;
    if (n != 2 || n_read != 0 || n_abort != 0 || n_idle != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: pre=%0d reads=%0d aborts=%0d idle=%0d required 2/0/0/0",
               n, n_read, n_abort, n_idle);
    end
    hold_cnt[0] = 0;
    drive_inputs();
    clear_trace();
    repeat (30) step();
    n_read  = 0;
    n_abort = 0;
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] == 3'b001) n_read++;
      if (tr_abort[i]) n_abort++;
    end
    tests_run++;
    if (tr_read[0] !== 3'b001 || n_read != 3 || n_abort != 0) begin
      tests_failed++;
      $display("FAIL stall_resume: first=%b reads=%0d aborts=%0d required 001/3/0",
               tr_read[0], n_read, n_abort);
    end
  endtask

  task automatic test_stall_abort();
    int n_abort = 0, ia = -1, nxt = -1, n_vc2 = 0;
    do_reset();
    push_frame(2, 4);
    drive_inputs();
    step();
    push_frame(0, 3);
    drive_inputs();
    step();
    tests_run++;
    if (obs_read !== 3'b100) begin
      tests_failed++;
      $display("FAIL abort_setup: read=%b required 100", obs_read);
    end
    hold_cnt[2] = 1000;
    drive_inputs();
    clear_trace();
    repeat (80) step();
    for (int i = 0; i < tr_abort.size(); i++) begin
      if (tr_abort[i]) begin
        n_abort++;
        if (ia < 0) ia = i;
      end
      if (ia >= 0 && i > ia && nxt < 0 && tr_read[i] != '0) nxt = i;
    end
    tests_run++;
    if (n_abort != 1 || ia != STALL - 1) begin
      tests_failed++;
      $display("FAIL abort_pulse: pulses=%0d at=%0d required 1 at %0d", n_abort, ia, STALL - 1);
    end
    tests_run++;
    if (nxt != ia + IFG + 1 || nxt < 0 || tr_read[nxt] !== 3'b001) begin
      tests_failed++;
      $display("FAIL abort_next: next_read_at=%0d abort_at=%0d required VC0 %0d cycles after abort",
               nxt, ia, IFG + 1);
    end
    hold_cnt[2] = 0;
    drive_inputs();
    clear_trace();
    repeat (40) step();
    for (int i = 0; i < tr_read.size(); i++) if (tr_read[i] == 3'b100) n_vc2++;
    tests_run++;
    if (n_vc2 != 3) begin
      tests_failed++;
      $display("FAIL abort_leftover: vc2_reads=%0d required=3", n_vc2);
    end
  endtask

  task automatic test_enable();
    int n_read = 0, n_busy = 0, n_vc0 = 0, n_vc1 = 0;
    bit hit = 0;
    do_reset();
    enable = 1'b0;
    push_frame(0, 4);
    push_frame(1, 2);
    drive_inputs();
    clear_trace();
    repeat (20) step();
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] != '0) n_read++;
      if (tr_busy[i]) n_busy++;
    end
    tests_run++;
    if (n_read != 0 || n_busy != 0) begin
      tests_failed++;
      $display("FAIL enable_block: reads=%0d busy=%0d required 0/0", n_read, n_busy);
    end
    enable = 1'b1;
    drive_inputs();
    for (int c = 0; c < 10 && !hit; c++) begin
      step();
      hit = (obs_read != '0);
    end
    tests_run++;
    if (!hit || obs_read !== 3'b001) begin
      tests_failed++;
      $display("FAIL enable_grant: read=%b within 10 cycles, required 001", obs_read);
    end
    enable = 1'b0;
    drive_inputs();
    clear_trace();
    repeat (60) step();
    for (int i = 0; i < tr_read.size(); i++) begin
      if (tr_read[i] == 3'b001) n_vc0++;
      if (tr_read[i] == 3'b010) n_vc1++;
    end
    tests_run++;
    if (n_vc0 != 3 || n_vc1 != 0 || tr_busy[tr_busy.size()-1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_drop: vc0=%0d vc1=%0d busy_end=%b required 3/0/0",
               n_vc0, n_vc1, tr_busy[tr_busy.size()-1]);
    end
    enable = 1'b1;
    drive_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_frame(1, 6);
    drive_inputs();
    repeat (3) step();
    tests_run++;
    if (obs_read !== 3'b010) begin
      tests_failed++;
      $display("FAIL rstmid_setup: read=%b required 010", obs_read);
    end
    push_frame(0, 3);
    drive_inputs();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    tests_run++;
    if (obs_read !== '0 || obs_tx !== 1'b0 || obs_busy !== 1'b0 ||
        obs_abort !== 1'b0 || obs_sel !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: read=%b tx=%b busy=%b abort=%b sel=%0d required all zero",
               obs_read, obs_tx, obs_busy, obs_abort, obs_sel);
    end
    clear_trace();
    repeat (5) step();
    tests_run++;
    if (tr_read[0] !== 3'b001) begin
      tests_failed++;
      $display("FAIL rstmid_winner: first_read=%b required 001", tr_read[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int v = 0; v < NV; v++) begin
        if (hold_cnt[v] > 0) hold_cnt[v]--;
        else if ($urandom_range(0, 29) == 0) hold_cnt[v] = $urandom_range(1, 8);
        else if ($urandom_range(0, 499) == 0) hold_cnt[v] = $urandom_range(60, 75);
      end
      if ($urandom_range(0, 3) == 0) begin
        int v = $urandom_range(0, NV - 1);
        if (vcq[v].size() < 24) push_frame(v, $urandom_range(1, 6));
      end
      if ($urandom_range(0, 79) == 0) enable = ~enable;
      drive_inputs();
      step();
    end
    enable = 1'b1;
  endtask

  initial begin
    drive_inputs();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall_resume();
    test_stall_abort();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
